// File: rtl/adc_spi_responder.sv
// SPI responder emulating an 8-channel 12-bit serial ADC: decodes the next-channel address from DIN and returns the selected channel on DOUT.
// Optional build macro ADC_SPI_RESPONDER_TRISTATE_EN releases DOUT to high-Z while idle or deselected.
module adc_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        ADC_SCLK,
  input  logic        ADC_CS_N,
  input  logic        ADC_DIN,
  output logic        ADC_DOUT,
  input  logic [11:0] CH0,
  input  logic [11:0] CH1,
  input  logic [11:0] CH2,
  input  logic [11:0] CH3,
  input  logic [11:0] CH4,
  input  logic [11:0] CH5,
  input  logic [11:0] CH6,
  input  logic [11:0] CH7,
  output logic [2:0]  LAST_ADDR,
  output logic        FRAME_DONE,
  output logic        FRAME_ERR
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_WAIT_CS
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_din_sync;
  logic [SYNC_STAGES-1:0] r_seen;
  logic                   r_sclk_hist;
  logic                   r_cs_hist;
  logic                   r_armed;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_next_addr, w_next_addr_nxt;
  logic [15:0] r_shreg, w_shreg_nxt;
  logic [4:0]  r_rcnt, w_rcnt_nxt;
  logic [2:0]  r_addr_cap, w_addr_cap_nxt;
  logic        r_dout, w_dout_nxt;
  logic [2:0]  r_last_addr, w_last_addr_nxt;
  logic        r_done, w_done_nxt;
  logic        r_err, w_err_nxt;

  logic        w_sclk_s, w_cs_s, w_din_s;
  logic        w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
  logic [4:0]  w_rcnt_inc;
  logic [11:0] w_ch [8];

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_din_s     = r_din_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_hist;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_hist;
  assign w_cs_rise   = w_cs_s & ~r_cs_hist;
  assign w_cs_fall   = ~w_cs_s & r_cs_hist;
  assign w_rcnt_inc  = r_rcnt + 5'd1;

  assign w_ch[0] = CH0;
  assign w_ch[1] = CH1;
  assign w_ch[2] = CH2;
  assign w_ch[3] = CH3;
  assign w_ch[4] = CH4;
  assign w_ch[5] = CH5;
  assign w_ch[6] = CH6;
  assign w_ch[7] = CH7;

  // r_seen marks when the synchronizer output holds a real pin sample rather than
  // its reset idle value; a frame may only start after CS_N has been seen high for real.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_sclk_sync <= '1;
      r_cs_sync   <= '1;
      r_din_sync  <= '0;
      r_seen      <= '0;
      r_sclk_hist <= 1'b1;
      r_cs_hist   <= 1'b1;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], ADC_SCLK};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], ADC_CS_N};
      r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], ADC_DIN};
      r_seen      <= {r_seen[SYNC_STAGES-2:0], 1'b1};
      r_sclk_hist <= w_sclk_s;
      r_cs_hist   <= w_cs_s;
      r_armed     <= r_armed | (r_seen[SYNC_STAGES-1] & w_cs_s);
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_next_addr <= '0;
      r_shreg     <= '0;
      r_rcnt      <= '0;
      r_addr_cap  <= '0;
      r_dout      <= 1'b0;
      r_last_addr <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_next_addr <= w_next_addr_nxt;
      r_shreg     <= w_shreg_nxt;
      r_rcnt      <= w_rcnt_nxt;
      r_addr_cap  <= w_addr_cap_nxt;
      r_dout      <= w_dout_nxt;
      r_last_addr <= w_last_addr_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_next_addr_nxt = r_next_addr;
    w_shreg_nxt     = r_shreg;
    w_rcnt_nxt      = r_rcnt;
    w_addr_cap_nxt  = r_addr_cap;
    w_dout_nxt      = r_dout;
    w_last_addr_nxt = r_last_addr;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_dout_nxt = 1'b0;
        if (w_cs_fall && r_armed) begin
          w_shreg_nxt = {4'b0000, w_ch[r_next_addr]};
          w_rcnt_nxt  = '0;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // CS_N edge takes priority; a coincident SCLK edge is dropped.
        if (w_cs_rise) begin
          w_err_nxt   = 1'b1;
          w_dout_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else if (w_sclk_rise) begin
          w_rcnt_nxt = w_rcnt_inc;
          case (w_rcnt_inc)
            5'd3:    w_addr_cap_nxt[2] = w_din_s;
            5'd4:    w_addr_cap_nxt[1] = w_din_s;
            5'd5:    w_addr_cap_nxt[0] = w_din_s;
            default: ;
          endcase
          if (w_rcnt_inc == 5'd16) begin
            w_next_addr_nxt = r_addr_cap;
            w_last_addr_nxt = r_next_addr;
            w_done_nxt      = 1'b1;
            w_dout_nxt      = 1'b0;
            w_state_nxt     = ST_WAIT_CS;
          end
        end else if (w_sclk_fall && r_rcnt != 5'd0 && r_rcnt < 5'd16) begin
          w_shreg_nxt = {r_shreg[14:0], 1'b0};
          w_dout_nxt  = r_shreg[14];
        end
      end
      ST_WAIT_CS: begin
        w_dout_nxt = 1'b0;
        if (w_cs_s) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_dout_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef ADC_SPI_RESPONDER_TRISTATE_EN
  assign ADC_DOUT = (r_state == ST_IDLE || w_cs_s) ? 1'bz : r_dout;
`else
  assign ADC_DOUT = r_dout;
`endif

  assign LAST_ADDR  = r_last_addr;
  assign FRAME_DONE = r_done;
  assign FRAME_ERR  = r_err;

endmodule
